product_accumulator: RTL
========================

Name: product_accumulator

Overview:
- Downstream consumer of the 4x4 combinational multiplier's 8-bit product.
- Accumulates a programmed number of products (a dot-product / MAC burst) and presents the sum on a valid/ready output.
- Input side is a valid/ready handshake so the upstream operand driver can stall freely.
- Sole sequential stage between the multiplier and the result consumer.

Parameters:
- ACC_W, 12: accumulator/output width in bits. Default holds 16 x 225 = 3600 without overflow. Legal range 8..32.
- CNT_W, 4: burst-length field width. Maximum burst is 2^CNT_W products.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a burst; sampled only in IDLE
- len  input  CNT_W  products in the burst, latched on start; 0 means 2^CNT_W
- clear  input  1  synchronous abort; returns to IDLE
- in_valid  input  1  in_product is valid
- in_ready  output  1  block accepts a product this cycle
- in_product  input  8  unsigned product from the multiplier
- out_valid  output  1  out_sum/out_ovf are valid
- out_ready  input  1  consumer takes the result
- out_sum  output  ACC_W  accumulated sum, modulo 2^ACC_W
- out_ovf  output  1  sticky flag: a carry left bit ACC_W-1 during this burst
- busy  output  1  high in ACCUM or HOLD

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset (rst_n=0, asynchronous): state=IDLE; in_ready=0, out_valid=0, out_sum=0, out_ovf=0, busy=0; internal count=0, acc=0.
- All outputs are registered or decoded from the state register. There is no combinational path from in_* to out_*.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1: latch len (0 becomes 2^CNT_W), acc<=0, ovf<=0, count<=0, go to ACCUM.
- ACCUM:
  - in_ready=1, busy=1.
  - An accept is in_valid && in_ready: acc <= acc + zero_ext(in_product) mod 2^ACC_W; ovf <= ovf | carry-out; count++.
  - Cycles with in_valid=0 are bubbles: no change to acc or count.
  - An accept with count == len-1 goes to HOLD at that edge.
- HOLD:
  - out_valid=1, out_sum=acc, out_ovf=ovf; in_ready=0.
  - Outputs stay stable while out_ready=0.
  - out_valid && out_ready: go to IDLE; out_valid drops the next cycle. out_sum/out_ovf keep their last values.
- Latency: out_valid rises on the clock edge that captures the final accept, i.e. visible the cycle after the final handshake.
- Back-to-back bursts: IDLE lasts at least one cycle between bursts. Minimum period = len + 2 cycles.
- start outside IDLE is ignored. len changes outside IDLE have no effect.
- clear=1 in any state (synchronous): go to IDLE, acc=0, ovf=0, count=0, out_valid=0, out_sum=0, out_ovf=0. clear has priority over start and over any handshake in the same cycle.
- clear and start in the same cycle while in IDLE: clear wins and the burst does not start.
- rst_n asserted mid-burst: immediate return to the reset values. A partial sum is never presented.
- Width rule: in_product is zero-extended to ACC_W; the sum wraps modulo 2^ACC_W; out_ovf records any wrap.

Test Plan:
1. len=3; products 225 (15x15), 15 (3x5), 0, sent back-to-back -> out_valid the cycle after the 3rd accept; out_sum=240; out_ovf=0; busy high for 4 cycles.
2. len=2, products 36 and 49, in_valid toggling 1,0,0,1 -> only 2 accepts counted; out_sum=85.
3. HOLD with out_ready=0 for 5 cycles plus a start pulse -> out_sum=85 held, in_ready=0, start ignored. out_ready=1 -> IDLE the next cycle.
4. len=0 with 16 products of 225 -> out_sum=3600 (0xE10), out_ovf=0. With ACC_W=8, len=2, 225+225 -> out_sum=194 (0xC2), out_ovf=1.
5. clear after 2 of 4 accepts -> IDLE; outputs 0; a new start, len=1, product 9 -> out_sum=9.
6. rst_n low mid-ACCUM, asynchronously between edges -> outputs 0 immediately; a subsequent burst behaves as in scenario 1.

Source files
------------

// File: rtl/product_accumulator.sv
// product_accumulator: sums a burst of 8-bit multiplier products and
// returns the total on a valid/ready port (start/len/clear, in_*, out_*, busy).
module product_accumulator #(
  parameter int ACC_W = 12,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  localparam logic [CNT_W:0] ONE =
    {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W:0] FULL =
    {1'b1, {CNT_W{1'b0}}};

  state_t           state;
  logic [CNT_W:0]   len_q;
  logic [CNT_W:0]   count;
  logic [ACC_W-1:0] acc;
  logic             ovf;

  logic [ACC_W:0]   sum_w;
  logic [CNT_W:0]   len_ext;
  logic             accept;
  logic             last;

  // Carry out of the ACC_W-bit sum lands in sum_w[ACC_W].
  assign sum_w = {1'b0, acc}
    + {{(ACC_W + 1 - 8){1'b0}}, in_product};

  // A zero length field encodes the full 2^CNT_W burst.
  assign len_ext = (len == '0) ? FULL
                               : {1'b0, len};

  assign accept = in_valid && (state == ACCUM);
  assign last   = (count == (len_q - ONE));

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      len_q   <= '0;
      count   <= '0;
      acc     <= '0;
      ovf     <= 1'b0;
      out_sum <= '0;
      out_ovf <= 1'b0;
    end else if (clear) begin
      state   <= IDLE;
      count   <= '0;
      acc     <= '0;
      ovf     <= 1'b0;
      out_sum <= '0;
      out_ovf <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            len_q <= len_ext;
            count <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc   <= sum_w[ACC_W-1:0];
            ovf   <= ovf | sum_w[ACC_W];
            count <= count + ONE;
            // Result registers load on the final accept so
            // they hold the burst total after leaving HOLD.
            if (last) begin
              out_sum <= sum_w[ACC_W-1:0];
              out_ovf <= ovf | sum_w[ACC_W];
              state   <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
